// File: rtl/b205_led_pkg.sv
// Shared types and constants for the B205 RX2 status-LED sequencer.
package b205_led_pkg;

  typedef enum logic [2:0] {
    ST_SWEEP,
    ST_IDLE,
    ST_RX,
    ST_TX,
    ST_FLASH
  } state_t;

  localparam int BRIGHT_LSB    = 0;
  localparam int FORCE_EN_BIT  = 8;
  localparam int FORCE_RGB_LSB = 9;

  // Colours are {r,g,b}, 1 = lit.
  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

endpackage

// File: rtl/b205_led_pwm.sv
// Global-brightness PWM and registered active-low LED drivers.
module b205_led_pwm
  import b205_led_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb,
  input  logic [7:0] brightness,
  output logic       led_r_n,
  output logic       led_g_n,
  output logic       led_b_n
);

  logic [7:0] pwm_cnt;
  logic       on;

  assign on = (pwm_cnt < brightness);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      led_r_n <= 1'b1;
      led_g_n <= 1'b1;
      led_b_n <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      led_r_n <= ~(rgb[2] & on);
      led_g_n <= ~(rgb[1] & on);
      led_b_n <= ~(rgb[0] & on);
    end
  end

endmodule

// File: rtl/b205_led_seq.sv
// B205 RX2 status-LED sequencer: power-on sweep, status colours,
// error flash, forced colour and global PWM brightness.
module b205_led_seq
  import b205_led_pkg::*;
#(
  parameter int         TICK_DIV = 40000,
  parameter logic [7:0] SR_BASE  = 8'd0,
  parameter int         SWEEP_MS = 250,
  parameter int         FLASH_MS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        ext_ref_locked,
  input  logic        rx_active,
  input  logic        tx_active,
  input  logic        err_pulse,
  output logic        led_r_n,
  output logic        led_g_n,
  output logic        led_b_n
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [15:0] SW1    = 16'(SWEEP_MS);
  localparam logic [15:0] SW2    = 16'(2 * SWEEP_MS);
  localparam logic [15:0] SW_END = 16'(3 * SWEEP_MS - 1);
  localparam logic [15:0] FL1    = 16'(FLASH_MS);
  localparam logic [15:0] FL2    = 16'(2 * FLASH_MS);
  localparam logic [15:0] FL3    = 16'(3 * FLASH_MS);
  localparam logic [15:0] FL4    = 16'(4 * FLASH_MS);
  localparam logic [15:0] FL5    = 16'(5 * FLASH_MS);
  localparam logic [15:0] FL_END = 16'(6 * FLASH_MS - 1);

  if (TICK_DIV < 1 || SWEEP_MS < 1 || FLASH_MS < 1 ||
      3 * SWEEP_MS > 65535 || 6 * FLASH_MS > 65535) begin : g_param_chk
    $error("b205_led_seq: dwell parameters out of range");
  end

  logic [7:0]  brightness;
  logic        force_en;
  logic [2:0]  force_rgb;
  logic [19:0] unused_data;

  assign unused_data = set_data[31:12];

  always_ff @(posedge clk) begin
    if (reset) begin
      brightness <= 8'h80;
      force_en   <= 1'b0;
      force_rgb  <= RGB_OFF;
    end else if (set_stb && set_addr == SR_BASE) begin
      brightness <= set_data[BRIGHT_LSB +: 8];
      force_en   <= set_data[FORCE_EN_BIT];
      force_rgb  <= set_data[FORCE_RGB_LSB +: 3];
    end
  end

  state_t      state;
  state_t      status;
  logic [TW-1:0] tick_cnt;
  logic [15:0] ms_cnt;
  logic        tick;

  assign tick   = (tick_cnt == TICK_LAST);
  assign status = tx_active ? ST_TX :
                  rx_active ? ST_RX : ST_IDLE;

  // Tick phase restarts with ms_cnt so every dwell is exact from entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_SWEEP;
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick && ms_cnt != 16'hFFFF)
        ms_cnt <= ms_cnt + 16'd1;
      unique case (state)
        ST_SWEEP: begin
          if (tick && ms_cnt == SW_END) begin
            state    <= status;
            tick_cnt <= '0;
            ms_cnt   <= '0;
          end
        end
        ST_FLASH: begin
          if (err_pulse) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
          end else if (tick && ms_cnt == FL_END) begin
            state    <= status;
            tick_cnt <= '0;
            ms_cnt   <= '0;
          end
        end
        default: begin
          if (err_pulse) begin
            state    <= ST_FLASH;
            tick_cnt <= '0;
            ms_cnt   <= '0;
          end else if (status != state) begin
            state    <= status;
            tick_cnt <= '0;
            ms_cnt   <= '0;
          end
        end
      endcase
    end
  end

  logic       flash_on;
  logic [2:0] colour;

  assign flash_on = (ms_cnt < FL1) ||
                    (ms_cnt >= FL2 && ms_cnt < FL3) ||
                    (ms_cnt >= FL4 && ms_cnt < FL5);

  always_comb begin
    colour = RGB_OFF;
    unique case (state)
      ST_SWEEP: colour = (ms_cnt < SW1) ? RGB_RED :
                         (ms_cnt < SW2) ? RGB_GREEN : RGB_BLUE;
      ST_TX:    colour = RGB_RED;
      ST_RX:    colour = RGB_GREEN;
      ST_IDLE:  colour = ext_ref_locked ? RGB_BLUE : RGB_OFF;
      ST_FLASH: colour = flash_on ? RGB_RED : RGB_OFF;
      default:  colour = RGB_OFF;
    endcase
    if (force_en)
      colour = force_rgb;
  end

  b205_led_pwm u_pwm (
    .clk        (clk),
    .reset      (reset),
    .rgb        (colour),
    .brightness (brightness),
    .led_r_n    (led_r_n),
    .led_g_n    (led_g_n),
    .led_b_n    (led_b_n)
  );

endmodule
